mmu_icache_arb: RTL and testbench



---
 rtl/mmu_pkg.sv | 26 ++
 rtl/icache_dm.sv | 67 ++++++
 rtl/mmu_icache_arb.sv | 152 +++++++++++++++
 tb/tb_mmu_icache_arb.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared state encoding and geometry helpers for the MMU/icache slice.
// Optional write-snoop invalidation is enabled by MMU_ICACHE_SNOOP_EN.
package mmu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_e;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int tag_w(input int addr_w,
                               input int data_w,
                               input int lines);
    return addr_w - idx_w(lines) - off_w(data_w);
  endfunction

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: combinational lookup, sync fill and
// invalidate, async clear of the valid bits.
module icache_dm
  import mmu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LINES  = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [ADDR_W-off_w(DATA_W)-1:0]      i_rd_line,
  output logic                                 o_hit,
  output logic [DATA_W-1:0]                    o_rd_data,
  input  logic                                 i_wr_en,
  input  logic [ADDR_W-off_w(DATA_W)-1:0]      i_wr_line,
  input  logic [DATA_W-1:0]                    i_wr_data,
  input  logic                                 i_inv_en,
  input  logic [ADDR_W-off_w(DATA_W)-1:0]      i_inv_line
);

  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(ADDR_W, DATA_W, LINES);

  logic [LINES-1:0]  r_valid;
  logic [TW-1:0]     r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  logic [IW-1:0] w_ridx;
  logic [TW-1:0] w_rtag;
  logic [IW-1:0] w_widx;
  logic [TW-1:0] w_wtag;
  logic [IW-1:0] w_iidx;
  logic [TW-1:0] w_itag;
  logic          w_inv_hit;

  assign w_ridx = i_rd_line[IW-1:0];
  assign w_rtag = i_rd_line[IW +: TW];
  assign w_widx = i_wr_line[IW-1:0];
  assign w_wtag = i_wr_line[IW +: TW];
  assign w_iidx = i_inv_line[IW-1:0];
  assign w_itag = i_inv_line[IW +: TW];

  assign o_hit     = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag);
  assign o_rd_data = o_hit ? r_data[w_ridx] : '0;
  assign w_inv_hit = r_valid[w_iidx] && (r_tag[w_iidx] == w_itag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      if (i_inv_en && w_inv_hit)
        r_valid[w_iidx] <= 1'b0;
      if (i_wr_en)
        r_valid[w_widx] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[w_widx]  <= w_wtag;
      r_data[w_widx] <= i_wr_data;
    end
  end

endmodule

// File: rtl/mmu_icache_arb.sv
// Fetch/data arbiter in front of a single ready-based memory port.
// Define MMU_ICACHE_SNOOP_EN to invalidate lines hit by completed stores.
module mmu_icache_arb
  import mmu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 64,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              instr_req,
  output logic [DATA_W-1:0] instr_out,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enable,
  input  logic              write_enable,
  input  logic [BE_W-1:0]   byte_select,
  output logic [DATA_W-1:0] data_out,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int OW = off_w(DATA_W);
  localparam int LW = ADDR_W - OW;

  state_e            r_state;
  state_e            w_next;
  logic              r_wr;
  logic [DATA_W-1:0] r_dout;
  logic              w_hit;
  logic [DATA_W-1:0] w_idata;
  logic              w_imiss;
  logic              w_fill;
  logic              w_inv_en;
  logic [LW-1:0]     w_inv_line;

  assign w_imiss   = instr_req && !w_hit;
  assign instr_out = w_idata;
  assign data_out  = r_dout;

  icache_dm #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .LINES (LINES)
  ) u_icache (
    .clk       (clk),
    .rst_n     (reset),
    .i_rd_line (pc[ADDR_W-1:OW]),
    .o_hit     (w_hit),
    .o_rd_data (w_idata),
    .i_wr_en   (w_fill),
    .i_wr_line (pc[ADDR_W-1:OW]),
    .i_wr_data (mem_rdata),
    .i_inv_en  (w_inv_en),
    .i_inv_line(w_inv_line)
  );

  always_comb begin
    w_next    = r_state;
    stall     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    w_fill    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        stall = w_imiss || read_enable || write_enable;
        if (w_imiss)
          w_next = S_FILL;
        else if (read_enable || write_enable)
          w_next = S_DATA;
      end
      S_FILL: begin
        stall    = 1'b1;
        mem_re   = 1'b1;
        mem_addr = pc;
        mem_be   = '1;
        if (mem_ready) begin
          w_fill = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_DATA: begin
        stall    = 1'b1;
        mem_addr = data_addr;
        if (r_wr) begin
          mem_we    = 1'b1;
          mem_wdata = data_in;
          mem_be    = byte_select;
        end else begin
          mem_re = 1'b1;
          mem_be = '1;
        end
        if (mem_ready)
          w_next = S_RESP;
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE)
        r_wr <= write_enable;
      if (r_state == S_DATA && mem_ready && !r_wr)
        r_dout <= mem_rdata;
    end
  end

`ifdef MMU_ICACHE_SNOOP_EN
  logic          r_snoop;
  logic [LW-1:0] r_snoop_line;

  // Invalidate during RESP so the clear lands on the RESP->IDLE edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snoop      <= 1'b0;
      r_snoop_line <= '0;
    end else begin
      r_snoop <= (r_state == S_DATA) && mem_ready && r_wr;
      if (r_state == S_DATA)
        r_snoop_line <= data_addr[ADDR_W-1:OW];
    end
  end

  assign w_inv_en   = (r_state == S_RESP) && r_snoop;
  assign w_inv_line = r_snoop_line;
`else
  assign w_inv_en   = 1'b0;
  assign w_inv_line = '0;
`endif

endmodule

// File: tb/tb_mmu_icache_arb.sv
// Directed bench for mmu_icache_arb with a latency-programmable memory.
// Snoop expectations follow MMU_ICACHE_SNOOP_EN.
module tb_mmu_icache_arb;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        instr_req;
  logic [31:0] instr_out;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic        read_enable;
  logic        write_enable;
  logic [3:0]  byte_select;
  logic [31:0] data_out;
  logic        stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  mmu_icache_arb dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .instr_req   (instr_req),
    .instr_out   (instr_out),
    .data_addr   (data_addr),
    .data_in     (data_in),
    .read_enable (read_enable),
    .write_enable(write_enable),
    .byte_select (byte_select),
    .data_out    (data_out),
    .stall       (stall),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  `define CHK(tag, obs, exp) \
    begin \
      total++; \
      assert ((obs) === (exp)) else begin \
        bad++; \
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
      end \
    end

  logic [31:0] mem [1024];
  int          lat = 1;
  int          cnt = 0;
  int          re_cyc = 0;
  int          we_cyc = 0;
  int          wchg = 0;
  logic [31:0] wd0;
  logic [3:0]  be0;
  logic [31:0] last_addr = '0;
  logic [31:0] log_a [32];
  int          nlog = 0;

  // Memory responder: raises mem_ready in the lat-th cycle of a strobe.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_re || mem_we) begin
        cnt++;
        mem_rdata = mem[mem_addr[11:2]];
        last_addr = mem_addr;
        if (mem_re) re_cyc++;
        if (mem_we) begin
          we_cyc++;
          if (cnt == 1) begin
            wd0 = mem_wdata;
            be0 = mem_be;
          end else if (mem_wdata !== wd0 || mem_be !== be0) begin
            wchg++;
          end
        end
        if (cnt == lat) begin
          mem_ready = 1'b1;
          if (nlog < 32) log_a[nlog] = mem_addr;
          nlog++;
          if (mem_we)
            for (int b = 0; b < 4; b++)
              if (mem_be[b])
                mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          mem_ready = 1'b0;
        end
      end else begin
        cnt = 0;
        mem_ready = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_stall(output int n);
    n = 0;
    while (stall === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    if (n >= 50) begin
      total++;
      bad++;
      $error("FAIL stall_timeout observed=%0d expected<50", n);
    end
  endtask

  int          n;
  int          r0;
  int          w0;
  int          l0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hFFFF_FFFF;
    reset        = 1'b0;
    pc           = '0;
    instr_req    = 1'b0;
    data_addr    = '0;
    data_in      = '0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    byte_select  = '0;
    tick();
    tick();
    `CHK("rst_stall", stall, 1'b0)
    `CHK("rst_instr", instr_out, 32'h0)
    `CHK("rst_dout", data_out, 32'h0)
    `CHK("rst_re", mem_re, 1'b0)
    `CHK("rst_we", mem_we, 1'b0)
    `CHK("rst_be", mem_be, 4'h0)
    `CHK("rst_addr", mem_addr, 32'h0)
    `CHK("rst_wdata", mem_wdata, 32'h0)
    reset = 1'b1;
    tick();

    // cold fetch, latency 3
    mem[32'h40 >> 2] = 32'hDEAD_BEEF;
    lat = 3;
    pc = 32'h40;
    instr_req = 1'b1;
    #1;
    `CHK("cold_stall0", stall, 1'b1)
    wait_stall(n);
    `CHK("cold_stall_cycles", n, 4)
    `CHK("cold_instr", instr_out, 32'hDEAD_BEEF)
    `CHK("cold_memaddr", last_addr, 32'h40)
    r0 = re_cyc;
    tick();
    `CHK("refetch_stall", stall, 1'b0)
    `CHK("refetch_instr", instr_out, 32'hDEAD_BEEF)
    `CHK("refetch_no_re", re_cyc, r0)

    // conflict eviction: 0x140 shares the index of 0x40
    mem[32'h140 >> 2] = 32'h1111_1111;
    lat = 1;
    pc = 32'h140;
    #1;
    wait_stall(n);
    `CHK("conf_cycles", n, 2)
    `CHK("conf_instr", instr_out, 32'h1111_1111)
    mem[32'h40 >> 2] = 32'h2222_2222;
    pc = 32'h40;
    #1;
    `CHK("evict_miss", stall, 1'b1)
    wait_stall(n);
    `CHK("evict_cycles", n, 2)
    `CHK("evict_memaddr", last_addr, 32'h40)
    `CHK("evict_instr", instr_out, 32'h2222_2222)

    // fetch miss plus load together
    mem[32'h400 >> 2] = 32'h0F0F_1234;
    mem[32'h200 >> 2] = 32'hA5A5_C3C3;
    l0 = nlog;
    pc = 32'h400;
    data_addr = 32'h200;
    read_enable = 1'b1;
    #1;
    wait_stall(n);
    `CHK("both_cycles", n, 4)
    `CHK("both_first", log_a[l0], 32'h400)
    `CHK("both_second", log_a[l0+1], 32'h200)
    `CHK("both_ntxn", nlog - l0, 2)
    `CHK("both_dout", data_out, 32'hA5A5_C3C3)
    `CHK("both_instr", instr_out, 32'h0F0F_1234)
    read_enable = 1'b0;
    instr_req = 1'b0;
    tick();
    `CHK("both_idle_stall", stall, 1'b0)
    `CHK("both_dout_hold", data_out, 32'hA5A5_C3C3)

    // byte-enable store, latency 3
    w0 = we_cyc;
    lat = 3;
    data_addr = 32'h300;
    data_in = 32'h1234_5678;
    byte_select = 4'b0011;
    write_enable = 1'b1;
    #1;
    `CHK("st_decode_stall", stall, 1'b1)
    `CHK("st_decode_we", mem_we, 1'b0)
    tick();
    `CHK("st_we", mem_we, 1'b1)
    `CHK("st_be", mem_be, 4'b0011)
    `CHK("st_wdata", mem_wdata, 32'h1234_5678)
    `CHK("st_addr", mem_addr, 32'h300)
    wait_stall(n);
    `CHK("st_data_cycles", n, 3)
    `CHK("st_resp_we", mem_we, 1'b0)
    `CHK("st_we_cycles", we_cyc - w0, 3)
    `CHK("st_stable", wchg, 0)
    `CHK("st_dout_kept", data_out, 32'hA5A5_C3C3)
    `CHK("st_mem", mem[32'h300 >> 2], 32'hFFFF_5678)
    write_enable = 1'b0;
    tick();
    `CHK("st_no_dup", we_cyc - w0, 3)
    `CHK("st_after_stall", stall, 1'b0)

    // snoop behaviour on a cached line
    mem[32'h80 >> 2] = 32'hCAFE_F00D;
    lat = 1;
    pc = 32'h80;
    instr_req = 1'b1;
    #1;
    wait_stall(n);
    `CHK("sn_fill_cycles", n, 2)
    `CHK("sn_instr", instr_out, 32'hCAFE_F00D)
    instr_req = 1'b0;
    data_addr = 32'h80;
    data_in = 32'h0BAD_C0DE;
    byte_select = 4'hF;
    write_enable = 1'b1;
    #1;
    wait_stall(n);
    `CHK("sn_store_cycles", n, 2)
    write_enable = 1'b0;
    instr_req = 1'b1;
    #1;
    `CHK("sn_resp_instr", instr_out, 32'hCAFE_F00D)
    `CHK("sn_resp_stall", stall, 1'b0)
    tick();
`ifdef MMU_ICACHE_SNOOP_EN
    `CHK("sn_refetch_miss", stall, 1'b1)
    wait_stall(n);
    `CHK("sn_refetch_instr", instr_out, 32'h0BAD_C0DE)
`else
    `CHK("sn_refetch_hit", stall, 1'b0)
    `CHK("sn_refetch_stale", instr_out, 32'hCAFE_F00D)
`endif

    // reset during a fill
    mem[32'h500 >> 2] = 32'h55AA_55AA;
    lat = 5;
    pc = 32'h500;
    #1;
    `CHK("rf_miss", stall, 1'b1)
    tick();
    tick();
    `CHK("rf_re", mem_re, 1'b1)
    `CHK("rf_addr", mem_addr, 32'h500)
    reset = 1'b0;
    #1;
    `CHK("rf_re_drop", mem_re, 1'b0)
    `CHK("rf_addr_drop", mem_addr, 32'h0)
    `CHK("rf_be_drop", mem_be, 4'h0)
    instr_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    lat = 1;
    instr_req = 1'b1;
    #1;
    `CHK("rf_post_miss", stall, 1'b1)
    wait_stall(n);
    `CHK("rf_post_cycles", n, 2)
    `CHK("rf_post_instr", instr_out, 32'h55AA_55AA)
    pc = 32'h40;
    #1;
    `CHK("rf_cleared", stall, 1'b1)
    wait_stall(n);
    `CHK("rf_cleared_instr", instr_out, 32'h2222_2222)
    instr_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
